bf_stdout_uart: RTL and testbench

BF_STDOUT_UART -- requirements
Module: bf_stdout_uart

---
 rtl/bf_stdout_uart.sv | 180 ++++++++++++++++++
 tb/tb_bf_stdout_uart.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bf_stdout_uart.sv
// bf_stdout_uart: captures bytes from a processor output strobe into a small FIFO and
// serialises them onto an 8N1 UART line. Optional even parity bit when BF_UART_PARITY_EN
// is defined (frame becomes 8E1). Synchronous active-high reset.
module bf_stdout_uart #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    stdout,
  input  logic                          stdout_en,
  output logic                          stall,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = AW + 1;
  localparam int unsigned TimerW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef BF_UART_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        idx_q, idx_d;
  logic              tx_q, tx_d;
  logic [7:0]        shift_q;
  logic              en_q;
  logic              ovf_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [7:0]        mem [FIFO_DEPTH];

  logic accept, full, wr, pop, bit_end;

  // Edge-detect the strobe so a level held while the processor is halted counts once.
  assign accept  = stdout_en & ~en_q;
  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign wr      = accept & ~full;
  assign bit_end = (timer_q == TimerW'(CLKS_PER_BIT - 1));

  // Headroom of one entry so a byte already in flight from the processor still fits.
  assign stall      = (count_q >= CntW'(FIFO_DEPTH - 1));
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign overflow   = ovf_q;
  assign fifo_count = count_q;
  assign tx         = tx_q;

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= stdout;
  end

  // Strobe history: sampled even during reset so a held strobe is not taken on release.
  always_ff @(posedge clk) begin
    en_q <= stdout_en;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (accept && full) ovf_q <= 1'b1;
    end
  end

  // Transmitter state, bit timer, bit index, shift register and registered line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      if (pop) shift_q <= mem[rd_ptr_q];
    end
  end

  // Next-state logic; tx_d is the line value for the bit being entered.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StStart;
          tx_d    = 1'b0;
          timer_d = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          timer_d = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          timer_d = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef BF_UART_PARITY_EN
            state_d = StParity;
            tx_d    = ^shift_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[idx_q + 3'd1];
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
`ifdef BF_UART_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          timer_d = '0;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
`endif
      StStop: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_bf_stdout_uart.sv
// Bench for bf_stdout_uart (CLKS_PER_BIT=4, FIFO_DEPTH=4): directed scenarios followed by
// random traffic, every cycle compared against an occupancy/frame-schedule reference model.
module tb_bf_stdout_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef BF_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] stdout = 8'h00;
  logic       stdout_en = 1'b0;
  logic       stall, tx, busy, overflow;
  logic [2:0] fifo_count;

  bf_stdout_uart #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stdout    (stdout),
    .stdout_en (stdout_en),
    .stall     (stall),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: byte queue, sticky overflow, and the schedule of the frame on the line.
  logic [7:0] mq[$];
  logic       m_prev_en = 1'b0;
  logic       m_ovf = 1'b0;
  int         edge_n = 0;
  int         pop_edge = 0;
  int         free_at = 0;   // first edge at which the transmitter can take a new byte
  logic [7:0] cur_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef BF_UART_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic model_busy();
    return (mq.size() != 0) || (edge_n <= free_at - 2);
  endfunction

  function automatic logic model_tx();
    if (edge_n >= pop_edge && edge_n <= free_at - 2)
      return frame_bit(cur_byte, (edge_n - pop_edge) / CPB);
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic acc, do_pop, was_full;
    edge_n++;
    if (reset) begin
      mq.delete();
      m_ovf     = 1'b0;
      free_at   = 0;
      pop_edge  = 0;
      m_prev_en = stdout_en;
    end else begin
      acc       = stdout_en && !m_prev_en;
      m_prev_en = stdout_en;
      was_full  = (mq.size() == DEPTH);
      do_pop    = (mq.size() != 0) && (edge_n >= free_at);
      if (do_pop) begin
        cur_byte = mq.pop_front();
        pop_edge = edge_n;
        free_at  = edge_n + FRAME + 1;
      end
      if (acc) begin
        if (was_full) m_ovf = 1'b1;
        else mq.push_back(stdout);
      end
    end
  endtask

  task automatic check_state();
    chk("count", 32'(fifo_count), 32'(mq.size()));
    chk("stall", 32'(stall), 32'(mq.size() >= DEPTH - 1));
    chk("busy", 32'(busy), 32'(model_busy()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx", 32'(tx), 32'(model_tx()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  task automatic pulse(input logic [7:0] b, input int gap);
    stdout    = b;
    stdout_en = 1'b1;
    tick();
    stdout_en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (model_busy() && n < max) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(n < max), 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    int n;

    // Reset
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);

    // Single 0x48 pulse: full waveform checked per cycle by the model
    pulse(8'h48, 0);
    chk("acc_count", 32'(fifo_count), 32'd1);
    tick();
    chk("start_bit", 32'(tx), 32'd0);
    drain(200);
    chk("idle_after_48", 32'(busy), 32'd0);

    // Level held 20 cycles: one frame only
    stdout    = 8'h41;
    stdout_en = 1'b1;
    repeat (20) tick();
    stdout_en = 1'b0;
    drain(200);

    // Five pulses two cycles apart, stall ignored
    for (int i = 0; i < 5; i++) pulse(8'h31 + 8'(i), 1);
    drain(600);

    // Accept coinciding with a pop at count 2
    pulse(8'h61, 1);
    pulse(8'h62, 1);
    pulse(8'h63, 1);
    n = 0;
    while (!(mq.size() == 2 && edge_n + 1 >= free_at) && n < 300) begin
      tick();
      n++;
    end
    chk("simul_wait", 32'(n < 300), 32'd1);
    pulse(8'h64, 0);
    chk("simul_count", 32'(fifo_count), 32'd2);
    drain(600);

    // Overfill: sixth byte dropped, overflow sticky
    for (int i = 0; i < 6; i++) pulse(8'h70 + 8'(i), 1);
    chk("ovf_set", 32'(overflow), 32'd1);
    drain(600);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset ten cycles into a 0x55 frame
    pulse(8'h55, 0);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    repeat (60) tick();
    chk("abort_quiet", 32'(busy), 32'd0);

    // Strobe held through reset is not taken on release
    stdout    = 8'h5a;
    stdout_en = 1'b1;
    reset     = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("held_rst_count", 32'(fifo_count), 32'd0);
    stdout_en = 1'b0;
    repeat (3) tick();

    // Random traffic, occasionally ignoring stall, with rare resets
    for (int c = 0; c < 1500; c++) begin
      stdout    = 8'($urandom);
      stdout_en = ($urandom_range(0, 3) == 0) && (!stall || $urandom_range(0, 1) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset     = 1'b0;
    stdout_en = 1'b0;
    tick();
    drain(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
